tx_fifo_reader: RTL and testbench
=================================

Name: tx_fifo_reader

Overview:
- Read-side consumer of the MAC transmit FIFO. Pops 64-bit words from the FIFO read port (rdreq/q/rdempty) and re-frames them into a valid/ready transmit stream toward the 10G MAC TX path.
- Each frame in the FIFO is one header word followed by its data words.
- Strips the header, generates SOP/EOP and empty-byte count, drops malformed frames, and enforces a programmable back-to-back idle gap between frames.

Parameters:
- WIDTH, 64, FIFO and stream data width; fixed at 64 for this block.
- MAX_LEN, 9600, largest legal frame length in bytes; longer frames are dropped.
- GAPW, 8, width of the back-to-back gap configuration.

Ports:
- rdclk  in  1  single clock, FIFO read-side clock domain.
- aclr  in  1  asynchronous reset, active-high.
- rdreq  out  1  FIFO read request; q is valid the cycle after (non-showahead FIFO).
- q  in  WIDTH  FIFO read data.
- rdempty  in  1  FIFO empty flag.
- cfg_b2b_gap  in  GAPW  idle cycles to insert after each EOP handshake.
- tx_ready  in  1  downstream accept.
- tx_valid  out  1  stream word valid.
- tx_data  out  WIDTH  stream data, byte 0 in [7:0].
- tx_sop  out  1  first word of frame.
- tx_eop  out  1  last word of frame.
- tx_mty  out  3  empty bytes in the EOP word, 0..7; 0 when not EOP.
- frame_done  out  1  one-cycle pulse on the EOP handshake.
- drop_pulse  out  1  one-cycle pulse when a frame's last word is discarded.
- busy  out  1  high whenever state is not IDLE or the output buffer is non-empty.

Behaviour:
- Header word format: q[15:0] is the byte length len. q[63:16] is reserved and ignored.
- Word count and empty bytes: words = (len+7)>>3 using 17-bit arithmetic; mty = (8 - len[2:0]) & 7.
- States:
  - IDLE: if !rdempty, assert rdreq and go to HDR.
  - HDR: decode q.
    - len==0: pulse drop_pulse and return to IDLE. No data words are read.
    - len>MAX_LEN: go to DROP with remaining = words.
    - Otherwise: go to DATA with remaining = words.
  - DATA: issue reads until remaining reaches 0. Stay in DATA until the EOP word is accepted downstream, then go to GAP, or to IDLE if the gap is 0.
  - DROP: assert rdreq whenever !rdempty and remaining>0; returned words are discarded. When the last word returns, pulse drop_pulse and go to IDLE. No GAP is applied after a drop.
  - GAP: load the counter with cfg_b2b_gap (sampled on the EOP handshake) and decrement once per cycle. When it reaches 0, go to IDLE. No FIFO reads occur in GAP.
- Output buffer: 2-entry register FIFO holding {data, sop, eop, mty}.
  - In DATA, rdreq = !rdempty & remaining>0 & (occupancy + inflight - pop) < 2, where pop = tx_valid & tx_ready.
  - This sustains one word per cycle while tx_ready stays high.
- Latency: header rdreq at cycle T; header decoded at T+1, where the first data rdreq is also issued; data arrives at T+2; tx_valid=1 with tx_sop=1 at T+3.
- Handshake rules:
  - A word transfers when tx_valid & tx_ready.
  - While tx_valid is high and tx_ready is low, tx_data, tx_sop, tx_eop and tx_mty hold stable.
  - tx_valid never drops without a transfer.
- Single-word frame (len 1..8): tx_sop and tx_eop are both 1 on the same word.
- FIFO underrun mid-frame (rdempty=1 in DATA): stall with no rdreq. tx_valid falls once the buffer drains, and the frame resumes when data arrives. This is not an error.
- rdreq is never asserted while rdempty=1.
- aclr: all outputs are 0, state is IDLE, buffer and in-flight read are discarded, gap counter is 0. A frame in progress is abandoned; the FIFO is cleared by the same aclr.

Optional Feature:
- Macro TXRD_STATS_EN.
- Defined: adds outputs stat_frames[31:0] (EOP handshakes), stat_drops[31:0] (drop_pulse events) and stat_bytes[47:0] (sum of len of sent frames).
  - All counters wrap modulo 2^n and reset to 0 on aclr.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- len=64 frame (header plus 8 words), tx_ready=1, gap=0: first tx_valid at T+3; 8 consecutive words; sop on word 0; eop on word 7 with mty=0; frame_done is one cycle.
- len=13: 2 words; eop word has mty=3. Then len=1: single word with sop=eop=1 and mty=7.
- gap=5 with two frames queued: the second header rdreq occurs exactly 5 idle cycles after the first EOP handshake.
- len=0 header then len=9601 (1201 words) then len=8: one drop_pulse for the zero-length frame; 1201 words discarded with one drop_pulse; the len=8 frame is output intact.
- tx_ready toggles 1,0,0,1 and rdempty is forced high mid-frame: data holds stable while stalled; no rdreq while empty; word order is preserved; no loss or duplication.
- aclr asserted mid-frame: outputs read 0 on the next edge and busy=0. After release, a new len=16 frame is output correctly.

Source files
------------

// File: rtl/tx_fifo_reader.sv
// tx_fifo_reader: read-side consumer of the MAC transmit FIFO.
// Pops {header, data...} frames from a non-showahead FIFO, strips the header and
// presents the payload as a valid/ready stream with SOP/EOP/MTY. It drops frames
// that are zero-length or oversized, and inserts a programmable idle gap after each frame.
// Optional statistics counters are enabled by defining TXRD_STATS_EN.
module tx_fifo_reader #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned MAX_LEN = 9600,
  parameter int unsigned GAPW    = 8
) (
  input  logic             rdclk,
  input  logic             aclr,
  output logic             rdreq,
  input  logic [WIDTH-1:0] q,
  input  logic             rdempty,
  input  logic [GAPW-1:0]  cfg_b2b_gap,
  input  logic             tx_ready,
  output logic             tx_valid,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_sop,
  output logic             tx_eop,
  output logic [2:0]       tx_mty,
  output logic             frame_done,
  output logic             drop_pulse,
  output logic             busy
`ifdef TXRD_STATS_EN
  ,
  output logic [31:0]      stat_frames,
  output logic [31:0]      stat_drops,
  output logic [47:0]      stat_bytes
`endif
);

  localparam int unsigned EW = WIDTH + 5;  // {data, sop, eop, mty}
  localparam logic [16:0] MaxLen = 17'(MAX_LEN);

  typedef enum logic [2:0] {StIdle, StHdr, StData, StDrop, StGap} state_e;

  state_e          state;
  logic [16:0]     remaining;  // data reads still to issue for this frame
  logic            first;      // next word pushed into the buffer is the SOP word
  logic [2:0]      frame_mty;
  logic            inflight;   // a data read was issued last cycle, word is on q now
  logic [GAPW-1:0] gap_cnt;

  // Output buffer: b0 is the head presented on tx_*, b1 the second entry.
  logic [EW-1:0]   b0, b1;
  logic [1:0]      count;

  logic [15:0]     hdr_len;
  logic [16:0]     hdr_words;
  logic [3:0]      hdr_mty_w;
  logic            hdr_zero, hdr_long;
  logic            pop, push, space, rd_hdr, rd_data, eop_new;
  logic [EW-1:0]   new_entry;

  assign hdr_len   = q[15:0];
  assign hdr_words = ({1'b0, hdr_len} + 17'd7) >> 3;
  assign hdr_mty_w = 4'd8 - {1'b0, hdr_len[2:0]};
  assign hdr_zero  = (hdr_len == 16'd0);
  assign hdr_long  = ({1'b0, hdr_len} > MaxLen);

  assign tx_valid = (count != 2'd0);
  assign pop      = tx_valid & tx_ready;
  assign push     = inflight & (state == StData);
  // Room for one more word once the current pop and the in-flight word settle.
  assign space    = ({1'b0, count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});

  assign {tx_data, tx_sop, tx_eop, tx_mty} = tx_valid ? b0 : '0;

  // The arriving word is the frame's last once every read has been issued.
  assign eop_new   = (remaining == 17'd0);
  assign new_entry = {q, first, eop_new, eop_new ? frame_mty : 3'd0};

  assign frame_done = pop & tx_eop;
  assign drop_pulse = ((state == StHdr) && hdr_zero) ||
                      ((state == StDrop) && inflight && (remaining == 17'd0));
  assign busy       = (state != StIdle) || (count != 2'd0);

  // FIFO read request decode; the header read in HDR overlaps the first data read.
  always_comb begin
    rd_hdr  = 1'b0;
    rd_data = 1'b0;
    unique case (state)
      StIdle:  rd_hdr  = !rdempty;
      StHdr:   rd_data = !rdempty && !hdr_zero && (hdr_long || space);
      StData:  rd_data = !rdempty && (remaining != 17'd0) && space;
      StDrop:  rd_data = !rdempty && (remaining != 17'd0);
      default: ;
    endcase
  end

  // Held low during aclr so the reader is silent while the FIFO is being cleared.
  assign rdreq = (rd_hdr | rd_data) & ~aclr;

  // Frame sequencing: header decode, data/drop read counting and the idle gap.
  always_ff @(posedge rdclk or posedge aclr) begin
    if (aclr) begin
      state     <= StIdle;
      remaining <= '0;
      first     <= 1'b0;
      frame_mty <= '0;
      inflight  <= 1'b0;
      gap_cnt   <= '0;
    end else begin
      inflight <= rd_data;
      unique case (state)
        StIdle: begin
          if (rd_hdr) state <= StHdr;
        end
        StHdr: begin
          frame_mty <= hdr_mty_w[2:0];
          first     <= 1'b1;
          remaining <= hdr_words - {16'b0, rd_data};
          if (hdr_zero)      state <= StIdle;
          else if (hdr_long) state <= StDrop;
          else               state <= StData;
        end
        StData: begin
          remaining <= remaining - {16'b0, rd_data};
          if (push) first <= 1'b0;
          if (frame_done) begin
            if (cfg_b2b_gap != '0) begin
              gap_cnt <= cfg_b2b_gap;
              state   <= StGap;
            end else begin
              state <= StIdle;
            end
          end
        end
        StDrop: begin
          remaining <= remaining - {16'b0, rd_data};
          if (drop_pulse) state <= StIdle;
        end
        StGap: begin
          gap_cnt <= gap_cnt - GAPW'(1);
          if (gap_cnt <= GAPW'(1)) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Two-entry output buffer; a push never meets a full buffer without a pop.
  always_ff @(posedge rdclk or posedge aclr) begin
    if (aclr) begin
      b0    <= '0;
      b1    <= '0;
      count <= '0;
    end else begin
      if (pop) begin
        if (count == 2'd2) begin
          b0 <= b1;
          if (push) b1 <= new_entry;
        end else if (push) begin
          b0 <= new_entry;
        end
      end else if (push) begin
        if (count == 2'd0) b0 <= new_entry;
        else               b1 <= new_entry;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef TXRD_STATS_EN
  logic [15:0] frame_len;

  // Statistics: frames sent, frames dropped and payload bytes sent, all wrapping.
  always_ff @(posedge rdclk or posedge aclr) begin
    if (aclr) begin
      frame_len   <= '0;
      stat_frames <= '0;
      stat_drops  <= '0;
      stat_bytes  <= '0;
    end else begin
      if (state == StHdr) frame_len <= hdr_len;
      stat_frames <= stat_frames + {31'b0, frame_done};
      stat_drops  <= stat_drops + {31'b0, drop_pulse};
      if (frame_done) stat_bytes <= stat_bytes + {32'b0, frame_len};
    end
  end
`endif

endmodule

// File: tb/tb_tx_fifo_reader.sv
// Bench for tx_fifo_reader: a behavioural FIFO feeds random frames, a monitor
// records the output stream, and each test compares against a frame-level model.
// Build with TXRD_STATS_EN defined to also check the statistics counters.
module tb_tx_fifo_reader;
  localparam int MaxLen = 9600;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  mty;
  } word_t;

  logic        rdclk = 1'b0;
  logic        aclr = 1'b1;
  logic        rdreq;
  logic [63:0] q = '0;
  logic        rdempty;
  logic [7:0]  cfg_b2b_gap = '0;
  logic        tx_ready = 1'b1;
  logic        tx_valid;
  logic [63:0] tx_data;
  logic        tx_sop, tx_eop;
  logic [2:0]  tx_mty;
  logic        frame_done, drop_pulse, busy;
`ifdef TXRD_STATS_EN
  logic [31:0] stat_frames, stat_drops;
  logic [47:0] stat_bytes;
`endif

  int checks = 0;
  int errors = 0;

  tx_fifo_reader dut (
    .rdclk       (rdclk),
    .aclr        (aclr),
    .rdreq       (rdreq),
    .q           (q),
    .rdempty     (rdempty),
    .cfg_b2b_gap (cfg_b2b_gap),
    .tx_ready    (tx_ready),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_sop      (tx_sop),
    .tx_eop      (tx_eop),
    .tx_mty      (tx_mty),
    .frame_done  (frame_done),
    .drop_pulse  (drop_pulse),
    .busy        (busy)
`ifdef TXRD_STATS_EN
    ,
    .stat_frames (stat_frames),
    .stat_drops  (stat_drops),
    .stat_bytes  (stat_bytes)
`endif
  );

  always #5 rdclk = ~rdclk;

  // Non-showahead FIFO model; cleared by the same aclr.
  logic [63:0] mem [16384];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  logic hold_empty = 1'b0;
  assign rdempty = (wr_ptr == rd_ptr) || hold_empty;

  always @(posedge rdclk or posedge aclr) begin
    if (aclr) begin
      rd_ptr <= wr_ptr;
      q      <= '0;
    end else if (rdreq && !rdempty) begin
      q      <= mem[rd_ptr % 16384];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Monitor: record transfers and protocol violations mid-cycle.
  word_t rx_q[$];
  int    rx_cyc[$];
  int    rdreq_cyc[$];
  int    cyc = 0;
  int    hold_viol = 0, rd_viol = 0, fd_viol = 0, drop_cnt = 0, done_cnt = 0;
  logic  stall_prev = 1'b0;
  word_t prev_w = '0;

  always @(posedge rdclk) cyc <= cyc + 1;

  always @(negedge rdclk) begin
    if (aclr) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev && (!tx_valid || {tx_data, tx_sop, tx_eop, tx_mty} !== prev_w))
        hold_viol <= hold_viol + 1;
      if (rdreq && rdempty) rd_viol <= rd_viol + 1;
      if (frame_done !== (tx_valid && tx_ready && tx_eop)) fd_viol <= fd_viol + 1;
      if (tx_valid && tx_ready) begin
        rx_q.push_back({tx_data, tx_sop, tx_eop, tx_mty});
        rx_cyc.push_back(cyc);
      end
      if (rdreq) rdreq_cyc.push_back(cyc);
      if (drop_pulse) drop_cnt <= drop_cnt + 1;
      if (frame_done) done_cnt <= done_cnt + 1;
      stall_prev <= tx_valid && !tx_ready;
      prev_w     <= {tx_data, tx_sop, tx_eop, tx_mty};
    end
  end

  // Reference model: expected stream and counters, derived per frame from its length.
  word_t   exp_q[$];
  int      exp_frames = 0;
  int      exp_drops = 0;
  longint  exp_bytes = 0;

  task automatic push_frame(input int len);
    int    nw;
    word_t w;
    nw = (len + 7) / 8;
    mem[wr_ptr % 16384] = {$urandom(), 16'($urandom()), 16'(len)};
    for (int i = 0; i < nw; i++) begin
      w.data = {$urandom(), $urandom()};
      mem[(wr_ptr + 1 + i) % 16384] = w.data;
      if (len >= 1 && len <= MaxLen) begin
        w.sop = (i == 0);
        w.eop = (i == nw - 1);
        w.mty = w.eop ? 3'((8 - len % 8) % 8) : 3'd0;
        exp_q.push_back(w);
      end
    end
    if (len == 0 || len > MaxLen) begin
      exp_drops++;
    end else begin
      exp_frames++;
      exp_bytes += len;
    end
    wr_ptr = wr_ptr + 1 + nw;
  endtask

  task automatic tick();
    @(posedge rdclk);
    #1;
  endtask

  task automatic clear_logs();
    rx_q.delete();
    rx_cyc.delete();
    rdreq_cyc.delete();
    exp_q.delete();
  endtask

  // Run until the FIFO is drained and the DUT is idle.
  // rmode: 0 ready high, 1 random, 2 pattern 1,0,0,1. emode: 0 none, 1 random, 2 forced window.
  task automatic drain(input int budget, input int rmode, input int emode, output bit timeout);
    timeout = 1'b1;
    for (int i = 0; i < budget; i++) begin
      case (rmode)
        1:       tx_ready = 1'($urandom_range(0, 1));
        2:       tx_ready = !((i % 4) == 1 || (i % 4) == 2);
        default: tx_ready = 1'b1;
      endcase
      case (emode)
        1:       hold_empty = ($urandom_range(0, 3) == 0);
        2:       hold_empty = (i >= 4 && i < 10);
        default: hold_empty = 1'b0;
      endcase
      tick();
      if (wr_ptr == rd_ptr && !busy && !hold_empty) begin
        timeout = 1'b0;
        break;
      end
    end
    tx_ready   = 1'b1;
    hold_empty = 1'b0;
  endtask

  task automatic test_reset();
    aclr = 1'b1;
    repeat (2) @(posedge rdclk);
    @(negedge rdclk);
    checks++;
    if ({rdreq, tx_valid, tx_sop, tx_eop, tx_mty, frame_done, drop_pulse, busy} !== 10'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0", {rdreq, tx_valid, tx_sop, tx_eop, tx_mty,
               frame_done, drop_pulse, busy});
    end
    checks++;
    if (tx_data !== 64'h0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", tx_data);
    end
    @(posedge rdclk);
    #1;
    aclr = 1'b0;
    tick();
    checks++;
    if ({busy, rdreq, tx_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle: got %b want 000", {busy, rdreq, tx_valid});
    end
  endtask

  task automatic test_basic();
    bit    to;
    int    dd, fv, t0, first_v, span;
    word_t g;
    cfg_b2b_gap = 8'd0;
    clear_logs();
    dd = done_cnt;
    fv = fd_viol;
    push_frame(64);
    drain(200, 0, 0, to);
    checks++;
    if (to) begin errors++; $display("FAIL basic_timeout: got timeout want idle"); end
    t0      = (rdreq_cyc.size() > 0) ? rdreq_cyc[0] : -100;
    first_v = (rx_cyc.size() > 0) ? rx_cyc[0] : -1;
    checks++;
    if (first_v != t0 + 3) begin
      errors++;
      $display("FAIL basic_latency: got first valid at T+%0d want T+3", first_v - t0);
    end
    span = (rx_cyc.size() == 8) ? rx_cyc[7] - rx_cyc[0] : -1;
    checks++;
    if (span != 7) begin
      errors++;
      $display("FAIL basic_back_to_back: got span %0d want 7", span);
    end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL basic_count: got %0d words want %0d", rx_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      g = (i < rx_q.size()) ? rx_q[i] : '0;
      checks++;
      if (g !== exp_q[i]) begin
        errors++;
        $display("FAIL basic_word%0d: got %h want %h", i, g, exp_q[i]);
      end
    end
    checks++;
    if (done_cnt - dd != 1 || fd_viol != fv) begin
      errors++;
      $display("FAIL basic_frame_done: got %0d pulses (%0d bad) want 1 (0 bad)",
               done_cnt - dd, fd_viol - fv);
    end
  endtask

  task automatic test_short();
    bit    to;
    word_t g;
    cfg_b2b_gap = 8'd0;
    clear_logs();
    push_frame(13);
    push_frame(1);
    drain(200, 0, 0, to);
    checks++;
    if (to) begin errors++; $display("FAIL short_timeout: got timeout want idle"); end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL short_count: got %0d words want %0d", rx_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      g = (i < rx_q.size()) ? rx_q[i] : '0;
      checks++;
      if (g !== exp_q[i]) begin
        errors++;
        $display("FAIL short_word%0d: got %h want %h", i, g, exp_q[i]);
      end
    end
  endtask

  task automatic test_gap();
    bit    to;
    int    e, nr;
    word_t g;
    cfg_b2b_gap = 8'd5;
    clear_logs();
    push_frame(16);
    push_frame(16);
    drain(200, 0, 0, to);
    checks++;
    if (to) begin errors++; $display("FAIL gap_timeout: got timeout want idle"); end
    e = -1;
    foreach (rx_q[i]) if (rx_q[i].eop && e < 0) e = rx_cyc[i];
    nr = -1;
    foreach (rdreq_cyc[i]) if (rdreq_cyc[i] > e && nr < 0) nr = rdreq_cyc[i];
    checks++;
    if (e < 0 || nr != e + 6) begin
      errors++;
      $display("FAIL gap_next_header: got rdreq at E+%0d want E+6", nr - e);
    end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL gap_count: got %0d words want %0d", rx_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      g = (i < rx_q.size()) ? rx_q[i] : '0;
      checks++;
      if (g !== exp_q[i]) begin
        errors++;
        $display("FAIL gap_word%0d: got %h want %h", i, g, exp_q[i]);
      end
    end
    cfg_b2b_gap = 8'd0;
  endtask

  task automatic test_drop();
    bit    to;
    int    dp, dd, ed;
    word_t g;
    cfg_b2b_gap = 8'd0;
    clear_logs();
    dp = drop_cnt;
    dd = done_cnt;
    ed = exp_drops;
    push_frame(0);
    push_frame(9601);
    push_frame(MaxLen);
    push_frame(8);
    drain(6000, 0, 0, to);
    checks++;
    if (to) begin errors++; $display("FAIL drop_timeout: got timeout want idle"); end
    checks++;
    if (drop_cnt - dp != exp_drops - ed) begin
      errors++;
      $display("FAIL drop_pulses: got %0d want %0d", drop_cnt - dp, exp_drops - ed);
    end
    checks++;
    if (done_cnt - dd != 2) begin
      errors++;
      $display("FAIL drop_frames_sent: got %0d want 2", done_cnt - dd);
    end
    checks++;
    if (rd_ptr != wr_ptr) begin
      errors++;
      $display("FAIL drop_fifo_drained: got %0d words left want 0", wr_ptr - rd_ptr);
    end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL drop_count: got %0d words want %0d", rx_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      g = (i < rx_q.size()) ? rx_q[i] : '0;
      checks++;
      if (g !== exp_q[i]) begin
        errors++;
        $display("FAIL drop_word%0d: got %h want %h", i, g, exp_q[i]);
      end
    end
  endtask

  task automatic test_stall();
    bit    to;
    int    hv, rv;
    word_t g;
    cfg_b2b_gap = 8'd0;
    clear_logs();
    hv = hold_viol;
    rv = rd_viol;
    push_frame(40);
    push_frame(23);
    drain(400, 2, 2, to);
    checks++;
    if (to) begin errors++; $display("FAIL stall_timeout: got timeout want idle"); end
    checks++;
    if (hold_viol != hv) begin
      errors++;
      $display("FAIL stall_hold: got %0d unstable cycles want 0", hold_viol - hv);
    end
    checks++;
    if (rd_viol != rv) begin
      errors++;
      $display("FAIL stall_rdreq_empty: got %0d reads while empty want 0", rd_viol - rv);
    end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL stall_count: got %0d words want %0d", rx_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      g = (i < rx_q.size()) ? rx_q[i] : '0;
      checks++;
      if (g !== exp_q[i]) begin
        errors++;
        $display("FAIL stall_word%0d: got %h want %h", i, g, exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    bit    to;
    int    dp, ed, hv, rv, fv, len;
    word_t g;
    cfg_b2b_gap = 8'($urandom_range(0, 3));
    clear_logs();
    dp = drop_cnt;
    ed = exp_drops;
    hv = hold_viol;
    rv = rd_viol;
    fv = fd_viol;
    for (int f = 0; f < 20; f++) begin
      len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 200);
      push_frame(len);
    end
    drain(8000, 1, 1, to);
    checks++;
    if (to) begin errors++; $display("FAIL random_timeout: got timeout want idle"); end
    checks++;
    if (drop_cnt - dp != exp_drops - ed) begin
      errors++;
      $display("FAIL random_drops: got %0d want %0d", drop_cnt - dp, exp_drops - ed);
    end
    checks++;
    if (hold_viol != hv || rd_viol != rv || fd_viol != fv) begin
      errors++;
      $display("FAIL random_protocol: got hold=%0d rd=%0d fd=%0d want 0 0 0",
               hold_viol - hv, rd_viol - rv, fd_viol - fv);
    end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random_count: got %0d words want %0d", rx_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      g = (i < rx_q.size()) ? rx_q[i] : '0;
      checks++;
      if (g !== exp_q[i]) begin
        errors++;
        $display("FAIL random_word%0d: got %h want %h", i, g, exp_q[i]);
      end
    end
    cfg_b2b_gap = 8'd0;
  endtask

  task automatic test_aclr_mid();
    bit    to, seen;
    word_t g;
    cfg_b2b_gap = 8'd0;
    clear_logs();
    push_frame(64);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = tx_valid;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL aclr_frame_start: got no tx_valid want 1"); end
    tick();
    tick();
    aclr = 1'b1;
    @(negedge rdclk);
    checks++;
    if ({rdreq, tx_valid, tx_sop, tx_eop, tx_mty, frame_done, drop_pulse, busy} !== 10'b0) begin
      errors++;
      $display("FAIL aclr_ctrl: got %b want 0", {rdreq, tx_valid, tx_sop, tx_eop, tx_mty,
               frame_done, drop_pulse, busy});
    end
    checks++;
    if (tx_data !== 64'h0) begin
      errors++;
      $display("FAIL aclr_data: got %h want 0", tx_data);
    end
    @(posedge rdclk);
    #1;
    aclr = 1'b0;
    clear_logs();
    exp_frames = 0;
    exp_drops  = 0;
    exp_bytes  = 0;
    push_frame(16);
    drain(200, 0, 0, to);
    checks++;
    if (to) begin errors++; $display("FAIL aclr_timeout: got timeout want idle"); end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL aclr_count: got %0d words want %0d", rx_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      g = (i < rx_q.size()) ? rx_q[i] : '0;
      checks++;
      if (g !== exp_q[i]) begin
        errors++;
        $display("FAIL aclr_word%0d: got %h want %h", i, g, exp_q[i]);
      end
    end
  endtask

`ifdef TXRD_STATS_EN
  task automatic test_stats();
    checks++;
    if (stat_frames !== 32'(exp_frames)) begin
      errors++;
      $display("FAIL stats_frames: got %0d want %0d", stat_frames, exp_frames);
    end
    checks++;
    if (stat_drops !== 32'(exp_drops)) begin
      errors++;
      $display("FAIL stats_drops: got %0d want %0d", stat_drops, exp_drops);
    end
    checks++;
    if (stat_bytes !== 48'(exp_bytes)) begin
      errors++;
      $display("FAIL stats_bytes: got %0d want %0d", stat_bytes, exp_bytes);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_short();
    test_gap();
    test_drop();
    test_stall();
    test_random();
    test_aclr_mid();
    push_frame(0);
    push_frame(37);
    begin
      bit to;
      drain(200, 0, 0, to);
      checks++;
      if (to) begin errors++; $display("FAIL final_timeout: got timeout want idle"); end
    end
`ifdef TXRD_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
